// File: rtl/seq_shifter.sv
// ---------------------------------------------------------------------------
// seq_shifter
//   Multi-cycle shifter. Accepts an operand, shift amount and mode over a
//   valid/ready handshake, shifts by up to STEP bits per clock, then holds
//   the result and carry-out until the consumer takes them.
//
//   Parameters
//     WIDTH  operand/result width (>= 2)
//     STEP   maximum bits shifted per clock (1..WIDTH)
//     AMT_W  shift-amount width, derived as $clog2(WIDTH)
//
//   Ports
//     clk        rising-edge clock
//     reset_n    asynchronous active-low reset
//     in_valid   request valid
//     in_ready   block can accept a request (IDLE only)
//     in_data    operand
//     in_amt     shift amount, values >= WIDTH clamp to WIDTH-1
//     in_mode    00 LSL, 01 LSR, 10 ASR, 11 ROR / pass-through
//     out_valid  result valid (DONE)
//     out_ready  consumer accepts the result
//     out_data   shifted result
//     out_carry  last bit shifted out (0 when amt==0)
//
//   Build option
//     SEQ_SHIFTER_ROR_EN  defined: mode 11 rotates right.
//                         undefined: mode 11 passes in_data through with
//                         amt forced to 0 and no rotate datapath.
// ---------------------------------------------------------------------------
module seq_shifter #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    // One extra bit so WIDTH and STEP are representable even when WIDTH is
    // an exact power of two.
    localparam logic [AMT_W:0]   WIDTH_L = (AMT_W+1)'(WIDTH);
    localparam logic [AMT_W:0]   STEP_L  = (AMT_W+1)'(STEP);
    localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [1:0]       mode_q,  mode_d;
    logic             sign_q,  sign_d;
    logic             carry_q, carry_d;
    logic [AMT_W-1:0] rem_q,   rem_d;

    logic [AMT_W-1:0] amt_eff;
    logic [AMT_W:0]   step_k;

    // Single-bit shift of d in mode m; returns {bit shifted out, new data}.
    // ASR fills with the sign captured at acceptance, not the current MSB.
    function automatic logic [WIDTH:0] shift1(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       m,
        input logic             sign
    );
        logic [WIDTH:0] r;
        r = {1'b0, d};
        case (m)
            MODE_LSL: r = {d[WIDTH-1], d[WIDTH-2:0], 1'b0};
            MODE_LSR: r = {d[0], 1'b0, d[WIDTH-1:1]};
            MODE_ASR: r = {d[0], sign, d[WIDTH-1:1]};
`ifdef SEQ_SHIFTER_ROR_EN
            MODE_ROR: r = {d[0], d[0], d[WIDTH-1:1]};
`endif
            default:  r = {1'b0, d};
        endcase
        return r;
    endfunction

    // Effective amount: clamp to WIDTH-1; without the rotate option mode 11
    // degenerates to a zero-length pass-through.
    always_comb begin
        amt_eff = in_amt;
        if ({1'b0, in_amt} >= WIDTH_L) begin
            amt_eff = AMT_MAX;
        end
`ifndef SEQ_SHIFTER_ROR_EN
        if (in_mode == MODE_ROR) begin
            amt_eff = '0;
        end
`endif
    end

    // Bits to shift this clock: min(remaining, STEP).
    always_comb begin
        if ({1'b0, rem_q} > STEP_L) begin
            step_k = STEP_L;
        end else begin
            step_k = {1'b0, rem_q};
        end
    end

    always_comb begin
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] d;
        logic             c;

        state_d = state_q;
        data_d  = data_q;
        mode_d  = mode_q;
        sign_d  = sign_q;
        carry_d = carry_q;
        rem_d   = rem_q;
        r       = '0;
        d       = data_q;
        c       = carry_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    mode_d  = in_mode;
                    sign_d  = in_data[WIDTH-1];
                    carry_d = 1'b0;
                    rem_d   = amt_eff;
                    state_d = (amt_eff == '0) ? ST_DONE : ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                // Chain of up to STEP single-bit stages; only the first
                // step_k are applied, so the result matches a 1-bit/clock
                // shifter regardless of STEP.
                for (int unsigned i = 0; i < STEP; i++) begin
                    if ((AMT_W+1)'(i) < step_k) begin
                        r = shift1(d, mode_q, sign_q);
                        d = r[WIDTH-1:0];
                        c = r[WIDTH];
                    end
                end
                data_d  = d;
                carry_d = c;
                rem_d   = rem_q - step_k[AMT_W-1:0];
                if ({1'b0, rem_q} == step_k) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            mode_q  <= '0;
            sign_q  <= 1'b0;
            carry_q <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            sign_q  <= sign_d;
            carry_q <= carry_d;
            rem_q   <= rem_d;
        end
    end

    // Outputs are gated to DONE so no partial result is ever presented.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = out_valid ? data_q : '0;
    assign out_carry = out_valid ? carry_q : 1'b0;

endmodule

// File: tb/tb_seq_shifter.sv
module tb_seq_shifter;

    logic        clk;
    logic        reset_n;
    logic [15:0] in_data;
    logic [3:0]  in_amt;
    logic [1:0]  in_mode;
    logic        out_ready;

    logic        v1, r1, ov1, oc1;
    logic [15:0] od1;
    logic        v4, r4, ov4, oc4;
    logic [15:0] od4;

    int n_cmp;
    int n_bad;

    seq_shifter #(.WIDTH(16), .STEP(1)) u_s1 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(v1), .in_ready(r1),
        .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
        .out_valid(ov1), .out_ready(out_ready),
        .out_data(od1), .out_carry(oc1)
    );

    seq_shifter #(.WIDTH(16), .STEP(4)) u_s4 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(v4), .in_ready(r4),
        .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
        .out_valid(ov4), .out_ready(out_ready),
        .out_data(od4), .out_carry(oc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request to DUT sel (0: STEP=1, 1: STEP=4), count edges from
    // the accepting edge to out_valid, then check the held result.
    task automatic run_req(input int sel, input logic [15:0] d, input logic [3:0] a,
                           input logic [1:0] m, input logic [15:0] ed, input logic ec,
                           input int elat, input string tag);
        int  lat;
        logic got;
        @(negedge clk);
        in_data = d; in_amt = a; in_mode = m;
        if (sel == 0) v1 = 1'b1; else v4 = 1'b1;
        check_eq({tag, ".in_ready"}, (sel == 0) ? r1 : r4, 1'b1);
        @(posedge clk);
        #1;
        v1 = 1'b0; v4 = 1'b0;
        // Inputs changing after acceptance must be ignored.
        in_data = ~d; in_amt = 4'hF; in_mode = ~m;
        lat = 0;
        got = (sel == 0) ? ov1 : ov4;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            got = (sel == 0) ? ov1 : ov4;
        end
        check_eq({tag, ".latency"}, lat, elat);
        check_eq({tag, ".data"}, (sel == 0) ? od1 : od4, ed);
        check_eq({tag, ".carry"}, (sel == 0) ? oc1 : oc4, ec);
    endtask

    // With out_ready high the transfer happens on the next edge.
    task automatic finish_xfer(input int sel, input string tag);
        @(posedge clk);
        #1;
        check_eq({tag, ".post_valid"}, (sel == 0) ? ov1 : ov4, 1'b0);
        check_eq({tag, ".post_ready"}, (sel == 0) ? r1 : r4, 1'b1);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        reset_n = 1'b0; v1 = 1'b0; v4 = 1'b0; out_ready = 1'b1;
        in_data = '0; in_amt = '0; in_mode = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.in_ready1", r1, 1'b1);
        check_eq("rst.out_valid1", ov1, 1'b0);
        check_eq("rst.out_data1", od1, 16'h0000);
        check_eq("rst.out_carry1", oc1, 1'b0);
        check_eq("rst.in_ready4", r4, 1'b1);
        check_eq("rst.out_valid4", ov4, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        run_req(0, 16'h8001, 4'd1, 2'b00, 16'h0002, 1'b1, 1, "lsl1");
        finish_xfer(0, "lsl1");
        run_req(0, 16'h8000, 4'd4, 2'b10, 16'hF800, 1'b0, 4, "asr4");
        finish_xfer(0, "asr4");
        run_req(0, 16'h0003, 4'd1, 2'b01, 16'h0001, 1'b1, 1, "lsr1");
        finish_xfer(0, "lsr1");
`ifdef SEQ_SHIFTER_ROR_EN
        run_req(0, 16'h0008, 4'd4, 2'b11, 16'h8000, 1'b1, 4, "ror4");
        finish_xfer(0, "ror4");
        run_req(1, 16'h00F1, 4'd5, 2'b11, 16'h8807, 1'b1, 2, "ror5s4");
        finish_xfer(1, "ror5s4");
`else
        run_req(0, 16'h0008, 4'd4, 2'b11, 16'h0008, 1'b0, 0, "pass4");
        finish_xfer(0, "pass4");
        run_req(1, 16'h00F1, 4'd5, 2'b11, 16'h00F1, 1'b0, 0, "pass5s4");
        finish_xfer(1, "pass5s4");
`endif
        run_req(1, 16'hF000, 4'd6, 2'b01, 16'h03C0, 1'b0, 2, "lsr6s4");
        finish_xfer(1, "lsr6s4");
        run_req(1, 16'hF000, 4'd0, 2'b01, 16'hF000, 1'b0, 0, "lsr0s4");
        finish_xfer(1, "lsr0s4");
        run_req(1, 16'h8000, 4'd15, 2'b10, 16'hFFFF, 1'b0, 4, "asr15s4");
        finish_xfer(1, "asr15s4");
        run_req(1, 16'h0F0F, 4'd5, 2'b00, 16'hE1E0, 1'b1, 2, "lsl5s4");
        finish_xfer(1, "lsl5s4");

        // Back-pressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        run_req(0, 16'hF00F, 4'd3, 2'b00, 16'h8078, 1'b1, 3, "bp");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp.hold_valid", ov1, 1'b1);
            check_eq("bp.hold_data", od1, 16'h8078);
            check_eq("bp.hold_carry", oc1, 1'b1);
            check_eq("bp.hold_in_ready", r1, 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        finish_xfer(0, "bp");

        // Asynchronous reset in the middle of a long shift.
        @(negedge clk);
        in_data = 16'h1234; in_amt = 4'd10; in_mode = 2'b00; v1 = 1'b1;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_eq("mid.in_ready_busy", r1, 1'b0);
        reset_n = 1'b0;
        #1;
        check_eq("mid.out_valid", ov1, 1'b0);
        check_eq("mid.out_data", od1, 16'h0000);
        check_eq("mid.out_carry", oc1, 1'b0);
        check_eq("mid.in_ready", r1, 1'b1);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        run_req(0, 16'h0001, 4'd2, 2'b00, 16'h0004, 1'b0, 2, "postrst");
        finish_xfer(0, "postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard backstop in case the stimulus itself stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/seq_shifter.md
# seq_shifter

Parametrised, multi-cycle shifter: the next generation of the datapath's 16-bit combinational shifter. It accepts an operand, a shift amount and a mode over a valid/ready handshake. It shifts by up to STEP bits per clock, then holds the result and carry-out until the consumer takes them. It sits between the register-file read port and the writeback mux, where a full-width barrel shifter is too costly.

## Interface
- WIDTH, 16: operand/result width; ≥ 2.
- STEP, 1: maximum bits shifted per clock; 1 ≤ STEP ≤ WIDTH.
- AMT_W, $clog2(WIDTH): shift-amount width (derived, not overridden).
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_data  input  WIDTH  operand.
- in_amt  input  AMT_W  shift amount; values ≥ WIDTH are clamped to WIDTH-1.
- in_mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR (see Configuration).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  shifted result.
- out_carry  output  1  last bit shifted out (see Operation).

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready the block latches data, clamped amt and mode.
  - amt==0 → DONE.
  - otherwise → SHIFT with remaining=amt.
- SHIFT: each clock, shift by k=min(remaining, STEP) and decrement remaining by k. When remaining reaches 0 → DONE.
- DONE: out_valid=1. out_data/out_carry are held stable until out_valid&&out_ready, then → IDLE.
- in_ready=0 in SHIFT and DONE. There is no overlap of the next request with the current result.
- Mode behaviour:
  - LSL: zero-fill from LSB.
  - LSR: zero-fill from MSB.
  - ASR: MSB replicates the original in_data[WIDTH-1] on every step.
  - ROR: bits leaving the LSB re-enter at the MSB.
- out_carry:
  - LSL: input bit WIDTH-amt.
  - LSR/ASR: input bit amt-1.
  - ROR: result bit WIDTH-1.
  - amt==0: 0 for all modes.
- The result equals the single-step combinational equivalent, independent of STEP.
- in_data/in_amt/in_mode changes while not in IDLE are ignored.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_carry=0, internal remaining=0.
- out_valid rises ceil(amt/STEP) rising edges after the accepting edge. For amt==0 it is high in the cycle directly after acceptance.
- Minimum request-to-request period: ceil(amt/STEP)+2 cycles with out_ready held high.
- out_ready low in DONE: the block stalls indefinitely and outputs do not change.
- reset_n low at any time (mid-SHIFT, DONE under back-pressure): all state and outputs return to reset values immediately and asynchronously. The in-flight request is discarded and no partial result is presented.
- reset_n release: the first request can be accepted on the first rising edge after deassertion.

## Configuration
- SEQ_SHIFTER_ROR_EN defined: mode 11 performs ROR as above.
- SEQ_SHIFTER_ROR_EN undefined:
  - mode 11 is pass-through: amt is forced to 0.
  - out_data=in_data, out_carry=0, zero-cycle SHIFT (IDLE→DONE directly).
  - no rotate datapath is synthesised.

## Test plan
- WIDTH=16, STEP=1, LSL, in_data=0x8001, amt=1 → out_data=0x0002, out_carry=1; out_valid 1 edge after accept.
- WIDTH=16, STEP=1, ASR, in_data=0x8000, amt=4 → out_data=0xF800, out_carry=0; out_valid 4 edges after accept.
- WIDTH=16, ROR, in_data=0x0008, amt=4:
  - with SEQ_SHIFTER_ROR_EN → 0x8000, out_carry=1.
  - without it → 0x0008, out_carry=0, out_valid the cycle after accept.
- WIDTH=16, STEP=4, LSR, in_data=0xF000, amt=6 → out_data=0x03C0, out_carry=0; out_valid 2 edges after accept. Repeat with amt=0 → 0xF000, carry 0.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE → out_data/out_carry/out_valid stable and in_ready=0 throughout. Raising out_ready gives one transfer, then in_ready=1 the next cycle.
- Drop reset_n mid-SHIFT (amt=10, after 3 edges) → out_valid=0, out_data=0, in_ready=1 immediately. After release, a new LSL 0x0001 by 2 returns 0x0004.
